// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: receives a length-prefixed little-endian byte
// stream and writes 32-bit words into IMEM. Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte.
module imem_loader #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          rx_valid,
   input  logic [7:0]    rx_data,
   output logic          rx_ready,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [31:0]   wr_data,
   output logic          core_hold,
   output logic          done,
   output logic          error
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LEN   = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam logic [2:0] S_CSUM  = 3'd4;
`endif
   localparam logic [2:0] S_DONE  = 3'd5;
   localparam logic [2:0] S_ERR   = 3'd6;

   localparam logic [8:0] DEPTH_W = 9'(DEPTH);

   logic [2:0]  state;
   logic [1:0]  byte_cnt;
   logic [7:0]  word_idx;
   logic [7:0]  word_len;
   logic [23:0] asm_lo;
   logic        accept;
   logic        last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  csum_acc;
`endif

   assign accept    = rx_valid & rx_ready;
   // Evaluated during WRITE: the word being written is the final one.
   assign last_word = ({1'b0, word_idx} + 9'd1) >= {1'b0, word_len};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         byte_cnt <= 2'd0;
         word_idx <= 8'd0;
         word_len <= 8'd0;
         asm_lo   <= 24'd0;
         wr_addr  <= '0;
         wr_data  <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_acc <= 8'd0;
`endif
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state    <= S_LEN;
                  byte_cnt <= 2'd0;
                  word_idx <= 8'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_acc <= 8'd0;
`endif
               end
            end
            S_LEN: begin
               if (accept) begin
                  word_len <= rx_data;
                  if (rx_data != 8'd0 && {1'b0, rx_data} <= DEPTH_W)
                     state <= S_DATA;
                  else
                     state <= S_ERR;
               end
            end
            S_DATA: begin
               if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_acc <= csum_acc + rx_data;
`endif
                  byte_cnt <= byte_cnt + 2'd1;
                  case (byte_cnt)
                     2'd0: asm_lo[7:0]   <= rx_data;
                     2'd1: asm_lo[15:8]  <= rx_data;
                     2'd2: asm_lo[23:16] <= rx_data;
                     default: begin
                        // Fourth byte goes straight into the output word.
                        wr_data <= {rx_data, asm_lo};
                        wr_addr <= word_idx[AW-1:0];
                        state   <= S_WRITE;
                     end
                  endcase
               end
            end
            S_WRITE: begin
               word_idx <= word_idx + 8'd1;
               byte_cnt <= 2'd0;
               if (!last_word)
                  state <= S_DATA;
               else
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state <= S_CSUM;
`else
                  state <= S_DONE;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
               if (accept)
                  state <= (rx_data == csum_acc) ? S_DONE : S_ERR;
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      rx_ready  = 1'b0;
      case (state)
         S_LEN, S_DATA: rx_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM:        rx_ready = 1'b1;
`endif
         default:       rx_ready = 1'b0;
      endcase
      wr_en     = (state == S_WRITE);
      done      = (state == S_DONE);
      error     = (state == S_ERR);
      core_hold = (state != S_DONE);
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (default DEPTH=64).
`timescale 1ns/1ps
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_ready, wr_en, core_hold, done, error;
   logic [5:0]  wr_addr;
   logic [31:0] wr_data;

   int tests = 0;
   int fails = 0;

   int          log_n = 0;
   int          rdy_in_write = 0;
   logic [5:0]  log_addr [0:15];
   logic [31:0] log_data [0:15];

   imem_loader #(.DEPTH(64), .AW(6)) dut (
      .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .core_hold(core_hold), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   // Capture every write strobe seen at a rising edge.
   always @(posedge clk) begin
      if (wr_en) begin
         if (log_n < 16) begin
            log_addr[log_n] <= wr_addr;
            log_data[log_n] <= wr_data;
         end
         log_n <= log_n + 1;
         if (rx_ready) rdy_in_write <= rdy_in_write + 1;
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit gap);
      int guard;
      if (gap) begin
         rx_valid = 1'b0;
         @(negedge clk);
      end
      rx_valid = 1'b1;
      rx_data  = b;
      guard = 0;
      while (!rx_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) begin
         tests++; fails++;
         $display("FAIL send_byte_timeout byte=%h rx_ready never rose", b);
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_csum(input logic [7:0] b);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(b, 1'b0);
`else
      if (b == 8'hFF) rx_data = b;
      @(negedge clk);
`endif
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (core_hold !== 1'b1) begin fails++; $display("FAIL reset_core_hold got=%b exp=1", core_hold); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
      tests++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error got=%b exp=0", error); end
      tests++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL reset_rx_ready got=%b exp=0", rx_ready); end
      tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
      tests++; if (wr_addr !== 6'd0) begin fails++; $display("FAIL reset_wr_addr got=%h exp=0", wr_addr); end
      tests++; if (wr_data !== 32'd0) begin fails++; $display("FAIL reset_wr_data got=%h exp=0", wr_data); end
   endtask

   task automatic test_single_word();
      int n0;
      n0 = log_n;
      pulse_start();
      tests++; if (rx_ready !== 1'b1) begin fails++; $display("FAIL single_len_ready got=%b exp=1", rx_ready); end
      send_byte(8'h01, 1'b0);
      send_byte(8'h13, 1'b0);
      send_byte(8'h05, 1'b0);
      send_byte(8'h50, 1'b0);
      send_byte(8'h00, 1'b0);
      tests++; if (wr_en !== 1'b1) begin fails++; $display("FAIL single_wr_en got=%b exp=1", wr_en); end
      tests++; if (wr_addr !== 6'd0) begin fails++; $display("FAIL single_wr_addr got=%h exp=0", wr_addr); end
      tests++; if (wr_data !== 32'h00500513) begin fails++; $display("FAIL single_wr_data got=%h exp=00500513", wr_data); end
      tests++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL single_ready_in_write got=%b exp=0", rx_ready); end
      send_csum(8'h68);
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL single_done got=%b exp=1", done); end
      tests++; if (core_hold !== 1'b0) begin fails++; $display("FAIL single_core_hold got=%b exp=0", core_hold); end
      tests++; if (log_n - n0 !== 1) begin fails++; $display("FAIL single_write_count got=%0d exp=1", log_n - n0); end
      tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL single_wr_en_done got=%b exp=0", wr_en); end
   endtask

   task automatic test_bad_count();
      int n0;
      logic [7:0] bad [0:1];
      bad[0] = 8'h00;
      bad[1] = 8'h41;
      for (int i = 0; i < 2; i++) begin
         n0 = log_n;
         pulse_start();
         tests++; if (done !== 1'b0) begin fails++; $display("FAIL badcnt_done_cleared got=%b exp=0", done); end
         send_byte(bad[i], 1'b0);
         @(negedge clk);
         tests++; if (error !== 1'b1) begin fails++; $display("FAIL badcnt_error n=%h got=%b exp=1", bad[i], error); end
         tests++; if (core_hold !== 1'b1) begin fails++; $display("FAIL badcnt_core_hold n=%h got=%b exp=1", bad[i], core_hold); end
         tests++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL badcnt_rx_ready n=%h got=%b exp=0", bad[i], rx_ready); end
         tests++; if (log_n !== n0) begin fails++; $display("FAIL badcnt_no_write n=%h got=%0d exp=%0d", bad[i], log_n, n0); end
      end
   endtask

   task automatic test_toggle();
      int n0, r0;
      logic [7:0] bytes [0:7];
      bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
      bytes[4] = 8'hAA; bytes[5] = 8'hBB; bytes[6] = 8'hCC; bytes[7] = 8'hDD;
      n0 = log_n;
      r0 = rdy_in_write;
      pulse_start();
      send_byte(8'h02, 1'b1);
      for (int i = 0; i < 8; i++) send_byte(bytes[i], 1'b1);
      send_csum(8'hB8);
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL toggle_done got=%b exp=1", done); end
      tests++; if (log_n - n0 !== 2) begin fails++; $display("FAIL toggle_write_count got=%0d exp=2", log_n - n0); end
      tests++; if (log_addr[n0] !== 6'd0) begin fails++; $display("FAIL toggle_addr0 got=%h exp=0", log_addr[n0]); end
      tests++; if (log_data[n0] !== 32'h44332211) begin fails++; $display("FAIL toggle_data0 got=%h exp=44332211", log_data[n0]); end
      tests++; if (log_addr[n0+1] !== 6'd1) begin fails++; $display("FAIL toggle_addr1 got=%h exp=1", log_addr[n0+1]); end
      tests++; if (log_data[n0+1] !== 32'hDDCCBBAA) begin fails++; $display("FAIL toggle_data1 got=%h exp=ddccbbaa", log_data[n0+1]); end
      tests++; if (rdy_in_write !== r0) begin fails++; $display("FAIL toggle_ready_in_write got=%0d exp=%0d", rdy_in_write, r0); end
      tests++; if (wr_addr !== 6'd1 || wr_data !== 32'hDDCCBBAA) begin fails++; $display("FAIL toggle_hold got=%h/%h exp=1/ddccbbaa", wr_addr, wr_data); end
   endtask

   task automatic test_midload_reset();
      int n0;
      logic [7:0] b;
      n0 = log_n;
      pulse_start();
      send_byte(8'h03, 1'b0);
      for (int i = 0; i < 5; i++) send_byte(8'hF0 + 8'(i), 1'b0);
      reset = 1'b1;
      @(negedge clk);
      tests++; if (core_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin fails++; $display("FAIL midrst_status got=%b%b%b exp=100", core_hold, done, error); end
      tests++; if (rx_ready !== 1'b0 || wr_en !== 1'b0) begin fails++; $display("FAIL midrst_handshake got=%b%b exp=00", rx_ready, wr_en); end
      tests++; if (wr_addr !== 6'd0 || wr_data !== 32'd0) begin fails++; $display("FAIL midrst_wr_bus got=%h/%h exp=0/0", wr_addr, wr_data); end
      tests++; if (log_n - n0 !== 1) begin fails++; $display("FAIL midrst_writes got=%0d exp=1", log_n - n0); end
      reset = 1'b0;
      @(negedge clk);
      n0 = log_n;
      pulse_start();
      send_byte(8'h03, 1'b0);
      for (int i = 0; i < 12; i++) begin
         b = 8'(i + 1);
         send_byte(b, 1'b0);
      end
      send_csum(8'h4E);
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL reload_done got=%b exp=1", done); end
      tests++; if (log_n - n0 !== 3) begin fails++; $display("FAIL reload_writes got=%0d exp=3", log_n - n0); end
      tests++; if (log_addr[n0+2] !== 6'd2 || log_data[n0+2] !== 32'h0C0B0A09) begin fails++; $display("FAIL reload_word2 got=%h/%h exp=2/0c0b0a09", log_addr[n0+2], log_data[n0+2]); end
      tests++; if (log_data[n0] !== 32'h04030201) begin fails++; $display("FAIL reload_word0 got=%h exp=04030201", log_data[n0]); end
   endtask

   task automatic test_start_ignored();
      int n0;
      n0 = log_n;
      pulse_start();
      send_byte(8'h01, 1'b0);
      send_byte(8'hDE, 1'b0);
      send_byte(8'hAD, 1'b0);
      pulse_start();
      tests++; if (rx_ready !== 1'b1 || core_hold !== 1'b1) begin fails++; $display("FAIL startign_state got=%b%b exp=11", rx_ready, core_hold); end
      send_byte(8'hBE, 1'b0);
      send_byte(8'hEF, 1'b0);
      send_csum(8'h38);
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL startign_done got=%b exp=1", done); end
      tests++; if (log_n - n0 !== 1 || log_data[n0] !== 32'hEFBEADDE) begin fails++; $display("FAIL startign_word got=%0d/%h exp=1/efbeadde", log_n - n0, log_data[n0]); end
      pulse_start();
      tests++; if (core_hold !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL restart_hold got=%b%b exp=10", core_hold, done); end
      tests++; if (rx_ready !== 1'b1 || error !== 1'b0) begin fails++; $display("FAIL restart_in_len got=%b%b exp=10", rx_ready, error); end
      do_reset();
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      logic [7:0] cs [0:1];
      cs[0] = 8'h0A;
      cs[1] = 8'h0B;
      for (int i = 0; i < 2; i++) begin
         pulse_start();
         send_byte(8'h01, 1'b0);
         for (int j = 0; j < 4; j++) send_byte(8'(j + 1), 1'b0);
         send_csum(cs[i]);
         tests++; if (done !== (i == 0)) begin fails++; $display("FAIL csum_done cs=%h got=%b", cs[i], done); end
         tests++; if (error !== (i == 1)) begin fails++; $display("FAIL csum_error cs=%h got=%b", cs[i], error); end
         tests++; if (core_hold !== (i == 1)) begin fails++; $display("FAIL csum_core_hold cs=%h got=%b", cs[i], core_hold); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_word();
      test_bad_count();
      test_toggle();
      test_midload_reset();
      test_start_ignored();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 64: instruction-memory depth in 32-bit words; legal range 2..255.
REQ-002 Parameter AW, default 6: word-address width, equal to clog2(DEPTH).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  load-request pulse.
REQ-006 rx_valid  input  1  byte-stream valid.
REQ-007 rx_data  input  8  byte-stream data.
REQ-008 rx_ready  output  1  loader can accept a byte.
REQ-009 wr_en  output  1  instruction-memory write strobe.
REQ-010 wr_addr  output  AW  instruction-memory word address.
REQ-011 wr_data  output  32  instruction-memory write word.
REQ-012 core_hold  output  1  holds PC and core in reset while high.
REQ-013 done  output  1  load completed successfully.
REQ-014 error  output  1  load aborted; sticky until next start or reset.

Function
REQ-015 The FSM SHALL have states IDLE, LEN, DATA, WRITE, CSUM, DONE and ERR.
REQ-016 A byte SHALL be accepted only on a rising edge where rx_valid and rx_ready are both high; rx_data is ignored otherwise.
REQ-017 rx_ready SHALL be high only in LEN, DATA and CSUM.
REQ-018 In IDLE, DONE or ERR, start SHALL move the FSM to LEN, clear done and error, raise core_hold, and zero the word index and checksum accumulator.
REQ-019 start SHALL be ignored in LEN, DATA, WRITE and CSUM.
REQ-020 In LEN, the accepted byte N SHALL be the word count; for 1<=N<=DEPTH the FSM SHALL go to DATA, otherwise it SHALL go to ERR with nothing written.
REQ-021 In DATA, accepted bytes SHALL be packed little-endian: the first byte goes to bits 7:0 and the fourth to bits 31:24.
REQ-022 After the fourth byte of a word is accepted, the FSM SHALL enter WRITE for exactly one cycle.
REQ-023 In WRITE, wr_en SHALL be high, wr_data SHALL be the assembled word, and wr_addr SHALL be the word index (0 for the first word).
REQ-024 On leaving WRITE, the word index SHALL increment and the byte counter SHALL clear to 0.
REQ-025 On leaving WRITE, the FSM SHALL return to DATA if words written < N.
REQ-026 On leaving WRITE after the last word, the FSM SHALL go to DONE (or to CSUM, see REQ-035).
REQ-027 wr_en SHALL be low in every state other than WRITE.
REQ-028 wr_addr and wr_data SHALL hold their last values when wr_en is low.
REQ-029 Each accepted DATA byte SHALL be added into an 8-bit modulo-256 accumulator; the count byte SHALL NOT be added.
REQ-030 In DONE, done=1 and core_hold=0; in ERR, error=1 and core_hold=1.
REQ-031 In all other states, done=0 and core_hold=1.
REQ-032 A stalled stream (rx_valid low) SHALL leave the FSM in its current state indefinitely; there is no timeout.

Reset
REQ-033 On reset, including mid-load, the FSM SHALL go to IDLE with core_hold=1, done=0, error=0, rx_ready=0, wr_en=0, wr_addr=0, wr_data=0, and all counters and the accumulator at 0.
REQ-034 Words already written before a mid-load reset SHALL NOT be undone; reset SHALL NOT generate any write.

Configuration
REQ-035 With macro IMEM_LOADER_CHECKSUM_EN defined, the FSM SHALL go from the last WRITE to CSUM and accept one byte there.
REQ-036 In CSUM, if the accepted byte equals the accumulator the FSM SHALL go to DONE; otherwise it SHALL go to ERR (memory stays written, core stays held).
REQ-037 Without IMEM_LOADER_CHECKSUM_EN, the CSUM state and the accumulator SHALL be absent, and the last WRITE SHALL go directly to DONE.

Verification
REQ-038 Reset, start, stream 0x01,0x13,0x05,0x50,0x00 with rx_valid always high -> one wr_en pulse with wr_addr=0 and wr_data=0x00500513, then done=1 and core_hold=0.
REQ-039 Count byte 0x00, then separately count 0x41 (DEPTH=64) -> error=1, no wr_en pulse, core_hold=1.
REQ-040 N=2 with rx_valid toggling every other cycle -> writes at addresses 0 then 1 with correct words, and rx_ready=0 during each WRITE cycle.
REQ-041 Assert reset after the 6th byte of an N=3 load -> next cycle all outputs at reset values; a following start and full reload completes with done=1.
REQ-042 CHECKSUM_EN: N=1 with bytes 0x01,0x02,0x03,0x04 and checksum 0x0A -> done=1; same load with checksum 0x0B -> error=1 and core_hold=1.
REQ-043 start pulsed during DATA -> ignored and the load completes normally; start pulsed in DONE -> core_hold=1 and the FSM is in LEN.
